// File: rtl/flash_pp_pkg.sv
// Shared types and constants for the parallel-programming flash host.
// Optional RDY timeout is enabled by defining PP_TIMEOUT_EN.
package flash_pp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_DATA_L,
        ST_DATA_H,
        ST_WR_PULSE,
        ST_WAIT_RDY,
        ST_RD_L,
        ST_RD_H,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_ERASE = 2'b01,
        OP_WRITE = 2'b10,
        OP_READ  = 2'b11
    } op_t;

    localparam logic [1:0] XA_ADDR = 2'b00;
    localparam logic [1:0] XA_DATA = 2'b01;
    localparam logic [1:0] XA_CMD  = 2'b10;

    localparam logic [7:0] CMD_NOP         = 8'h00;
    localparam logic [7:0] CMD_CHIP_ERASE  = 8'h80;
    localparam logic [7:0] CMD_WRITE_FLASH = 8'h10;
    localparam logic [7:0] CMD_READ_FLASH  = 8'h02;

    // last_cmd carries a 9th bit so "no command loaded" never aliases a real byte.
    localparam logic [8:0] LAST_NONE = 9'h100;

    function automatic logic [7:0] op_cmd(input op_t op);
        case (op)
            OP_ERASE: op_cmd = CMD_CHIP_ERASE;
            OP_WRITE: op_cmd = CMD_WRITE_FLASH;
            OP_READ:  op_cmd = CMD_READ_FLASH;
            default:  op_cmd = CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/flash_pp_strobe.sv
// Setup / XTAL1 strobe / hold timing for one flash load; done pulses in the hold cycle.
module flash_pp_strobe
    import flash_pp_pkg::*;
#(
    parameter int XTAL_HI = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic xtal1,
    output logic done
);

    localparam logic [7:0] HOLD_CNT = 8'(XTAL_HI + 1);

    logic [7:0] cnt_q, cnt_d;
    logic       xtal1_q, xtal1_d;

    always_comb begin
        done    = go && (cnt_q == HOLD_CNT);
        cnt_d   = (go && !done) ? cnt_q + 8'd1 : '0;
        xtal1_d = go && (cnt_d != '0) && (cnt_d <= 8'(XTAL_HI));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            xtal1_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            xtal1_q <= xtal1_d;
        end
    end

    assign xtal1 = xtal1_q;

endmodule

// File: rtl/flash_pp_host.sv
// Parallel-programming flash host: erase, page write, word read over XA/BS1/XTAL1 strobes.
// Define PP_TIMEOUT_EN to bound the RDY wait and raise the sticky err flag.
module flash_pp_host
    import flash_pp_pkg::*;
#(
    parameter int XTAL_HI     = 2,
    parameter int WR_LO       = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [13:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_last,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        err,
    output logic [1:0]  XA,
    output logic        BS1,
    output logic        XTAL1,
    output logic        WR,
    output logic        OE,
    output logic [7:0]  DATA_out,
    output logic        DATA_oe,
    input  logic [7:0]  DATA_in,
    input  logic        RDY
);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [13:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        last_q, last_d;
    logic [8:0]  last_cmd_q, last_cmd_d;
    logic [7:0]  cyc_q, cyc_d;
    logic        wait_lo_q, wait_lo_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        ready_en_q, ready_en_d;
    logic [1:0]  xa_q, xa_d;
    logic        bs1_q, bs1_d;
    logic [7:0]  dout_q, dout_d;
    logic        doe_q, doe_d;
    logic        wr_n_q, wr_n_d;
    logic        oe_n_q, oe_n_d;
`ifdef PP_TIMEOUT_EN
    logic        err_q, err_d;
    logic [15:0] to_cnt_q, to_cnt_d;
`endif

    logic load_go, load_done;

    assign load_go = state_q inside {ST_CMD, ST_ADDR_H, ST_ADDR_L, ST_DATA_L, ST_DATA_H};

    flash_pp_strobe #(.XTAL_HI(XTAL_HI)) u_strobe (
        .clk  (clk),
        .rst  (rst),
        .go   (load_go),
        .xtal1(XTAL1),
        .done (load_done)
    );

`ifdef PP_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
    // Without the timeout feature TIMEOUT_CYC only has to be a legal 16-bit count.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_timeout_cfg_unused
    end
`endif

    assign req_ready = (state_q == ST_IDLE) && ready_en_q && RDY && !err;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        last_d      = last_q;
        last_cmd_d  = last_cmd_q;
        wait_lo_d   = wait_lo_q;
        rdata_d     = rdata_q;
        ready_en_d  = 1'b1;
`ifdef PP_TIMEOUT_EN
        err_d       = err_q;
        to_cnt_d    = to_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = op_t'(req_op);
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    last_d  = req_last;
                    if (op_t'(req_op) == OP_WRITE && last_cmd_q == {1'b0, CMD_WRITE_FLASH})
                        state_d = ST_ADDR_L;
                    else if (op_t'(req_op) == OP_READ && last_cmd_q == {1'b0, CMD_READ_FLASH})
                        state_d = ST_ADDR_H;
                    else
                        state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (load_done) begin
                    last_cmd_d = {1'b0, op_cmd(op_q)};
                    case (op_q)
                        OP_NOP: begin
                            state_d    = ST_IDLE;
                            last_cmd_d = LAST_NONE;
                        end
                        OP_ERASE: state_d = ST_WR_PULSE;
                        OP_WRITE: state_d = ST_ADDR_L;
                        default:  state_d = ST_ADDR_H;
                    endcase
                end
            end
            ST_ADDR_H: if (load_done) state_d = (op_q == OP_READ) ? ST_ADDR_L : ST_WR_PULSE;
            ST_ADDR_L: if (load_done) state_d = (op_q == OP_READ) ? ST_RD_L : ST_DATA_L;
            ST_DATA_L: if (load_done) state_d = ST_DATA_H;
            ST_DATA_H: if (load_done) state_d = last_q ? ST_ADDR_H : ST_IDLE;
            ST_WR_PULSE: if (cyc_q == 8'(WR_LO - 1)) state_d = ST_WAIT_RDY;
            ST_WAIT_RDY: begin
                // Phase 1: let the flash drop RDY (up to 4 cycles); phase 2: wait for it to rise.
                if (wait_lo_q) begin
                    if (!RDY || cyc_q == 8'd3) wait_lo_d = 1'b0;
                end else if (RDY) begin
                    state_d = ST_IDLE;
                    if (op_q == OP_ERASE) last_cmd_d = LAST_NONE;
`ifdef PP_TIMEOUT_EN
                end else if (to_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
`endif
                end
            end
            ST_RD_L: begin
                if (cyc_q == 8'd1) begin
                    rdata_d[7:0] = DATA_in;
                    state_d      = ST_RD_H;
                end
            end
            ST_RD_H: begin
                if (cyc_q == 8'd1) begin
                    rdata_d[15:8] = DATA_in;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) cyc_d = '0;
        else                    cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 8'd1;

        if (state_d == ST_WAIT_RDY && state_q != ST_WAIT_RDY) begin
            wait_lo_d = 1'b1;
`ifdef PP_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
        end

        rsp_valid_d = (state_d == ST_RESP);

        // Pins are decoded from the next state so they change together with it.
        xa_d   = XA_ADDR;
        bs1_d  = 1'b0;
        dout_d = '0;
        doe_d  = 1'b0;
        wr_n_d = 1'b1;
        oe_n_d = 1'b1;
        case (state_d)
            ST_CMD:      begin xa_d = XA_CMD; dout_d = op_cmd(op_d); doe_d = 1'b1; end
            ST_ADDR_H:   begin bs1_d = 1'b1; dout_d = {2'b00, addr_d[13:8]}; doe_d = 1'b1; end
            ST_ADDR_L:   begin dout_d = addr_d[7:0]; doe_d = 1'b1; end
            ST_DATA_L:   begin xa_d = XA_DATA; dout_d = wdata_d[7:0]; doe_d = 1'b1; end
            ST_DATA_H:   begin xa_d = XA_DATA; bs1_d = 1'b1; dout_d = wdata_d[15:8]; doe_d = 1'b1; end
            ST_WR_PULSE: wr_n_d = 1'b0;
            ST_RD_L:     oe_n_d = 1'b0;
            ST_RD_H:     begin oe_n_d = 1'b0; bs1_d = 1'b1; end
            default:     ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            addr_q      <= '0;
            wdata_q     <= '0;
            last_q      <= 1'b0;
            last_cmd_q  <= LAST_NONE;
            cyc_q       <= '0;
            wait_lo_q   <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            ready_en_q  <= 1'b0;
            xa_q        <= XA_ADDR;
            bs1_q       <= 1'b0;
            dout_q      <= '0;
            doe_q       <= 1'b0;
            wr_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
`ifdef PP_TIMEOUT_EN
            err_q       <= 1'b0;
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            last_q      <= last_d;
            last_cmd_q  <= last_cmd_d;
            cyc_q       <= cyc_d;
            wait_lo_q   <= wait_lo_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            ready_en_q  <= ready_en_d;
            xa_q        <= xa_d;
            bs1_q       <= bs1_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            wr_n_q      <= wr_n_d;
            oe_n_q      <= oe_n_d;
`ifdef PP_TIMEOUT_EN
            err_q       <= err_d;
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign XA        = xa_q;
    assign BS1       = bs1_q;
    assign DATA_out  = dout_q;
    assign DATA_oe   = doe_q;
    assign WR        = wr_n_q;
    assign OE        = oe_n_q;

endmodule

// File: tb/tb_flash_pp_host.sv
// Directed bench for flash_pp_host with a small flash pin model (RDY busy, read data mux).
// Define PP_TIMEOUT_EN to include the RDY timeout scenario.
module tb_flash_pp_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [13:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_last = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        err;
    logic [1:0]  XA;
    logic        BS1, XTAL1, WR, OE, DATA_oe;
    logic [7:0]  DATA_out;
    logic [7:0]  DATA_in;
    logic        RDY = 1'b1;

    always #5 clk = ~clk;

    flash_pp_host #(.XTAL_HI(2), .WR_LO(2), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
        .XA(XA), .BS1(BS1), .XTAL1(XTAL1), .WR(WR), .OE(OE),
        .DATA_out(DATA_out), .DATA_oe(DATA_oe), .DATA_in(DATA_in), .RDY(RDY)
    );

    int checks = 0;
    int errors = 0;

    // Flash model state: written by the model, configured by the stimulus.
    logic [15:0] rd_word = 16'h0000;
    int          busy_cycles = 5;
    logic        stick = 1'b0;
    logic        hang = 1'b0;
    int          busy_left = 0;

    // Monitor records.
    logic [10:0] ld_q[$];
    int          wr_pulses = 0, wr_len = 0, last_wr_len = 0;
    int          xtal_len = 0, xtal_bad = 0, oe_viol = 0, rsp_count = 0;
    logic [15:0] rsp_seen = '0;
    logic        prev_xtal = 1'b0, prev_wr = 1'b1;

    assign DATA_in = !OE ? (BS1 ? rd_word[15:8] : rd_word[7:0]) : 8'h00;

    always @(negedge clk) begin
        if (XTAL1 && !prev_xtal) ld_q.push_back({XA, BS1, DATA_out});
        if (XTAL1) xtal_len++;
        else if (prev_xtal) begin
            if (xtal_len != 2) xtal_bad++;
            xtal_len = 0;
        end
        if (!stick) hang = 1'b0;
        if (!WR) wr_len++;
        else if (!prev_wr) begin
            wr_pulses++;
            last_wr_len = wr_len;
            wr_len = 0;
            busy_left = busy_cycles;
            if (stick) hang = 1'b1;
        end else if (busy_left > 0) busy_left--;
        RDY = (busy_left == 0) && !hang;
        if (DATA_oe && !OE) oe_viol++;
        if (rsp_valid) begin
            rsp_count++;
            rsp_seen = rsp_rdata;
        end
        prev_xtal = XTAL1;
        prev_wr   = WR;
    end

    function automatic logic [10:0] ld(input logic [1:0] xa, input logic bs1, input logic [7:0] d);
        return {xa, bs1, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ld(input string tag, input int idx, input logic [10:0] exp);
        logic [10:0] obs;
        obs = (idx < ld_q.size()) ? ld_q[idx] : 11'bx;
        check(tag, {21'b0, obs}, {21'b0, exp});
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!req_ready && n < budget);
        check(tag, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [13:0] a, input logic [15:0] d, input logic l);
        req_op = op; req_addr = a; req_wdata = d; req_last = l;
        req_valid = 1'b1;
        @(negedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_pins"}, {23'b0, XA, BS1, XTAL1, WR, OE, DATA_oe, req_ready, rsp_valid},
              {23'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check({tag, "_dout"}, {24'b0, DATA_out}, 32'h0);
        check({tag, "_rdata"}, {16'b0, rsp_rdata}, 32'h0);
        check({tag, "_err"}, {31'b0, err}, 32'h0);
    endtask

    initial begin
        int base, wbase, rbase, n;

        // Reset values and req_ready release timing.
        repeat (3) @(negedge clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b0;
        check("ready_before_edge", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_after_edge", {31'b0, req_ready}, 32'd1);

        // Chip erase with a 50-cycle busy period.
        busy_cycles = 50;
        base = ld_q.size(); wbase = wr_pulses;
        @(negedge clk); #1;
        send(2'b01, 14'h0, 16'h0, 1'b0);
        wait_idle("erase_idle", 300);
        check("erase_nloads", ld_q.size() - base, 32'd1);
        check_ld("erase_cmd", base, ld(2'b10, 1'b0, 8'h80));
        check("erase_wr_pulses", wr_pulses - wbase, 32'd1);
        check("erase_wr_len", last_wr_len, 32'd2);
        check("erase_err", {31'b0, err}, 32'd0);

        // Page write: two words, commit on the second.
        busy_cycles = 5;
        base = ld_q.size(); wbase = wr_pulses;
        send(2'b10, 14'h0005, 16'hA55A, 1'b0);
        wait_idle("wr1_idle", 100);
        check("wr1_no_pulse", wr_pulses - wbase, 32'd0);
        send(2'b10, 14'h0006, 16'h1234, 1'b1);
        wait_idle("wr2_idle", 100);
        check("page_nloads", ld_q.size() - base, 32'd8);
        check_ld("page_cmd",    base + 0, ld(2'b10, 1'b0, 8'h10));
        check_ld("page_addrl0", base + 1, ld(2'b00, 1'b0, 8'h05));
        check_ld("page_datal0", base + 2, ld(2'b01, 1'b0, 8'h5A));
        check_ld("page_datah0", base + 3, ld(2'b01, 1'b1, 8'hA5));
        check_ld("page_addrl1", base + 4, ld(2'b00, 1'b0, 8'h06));
        check_ld("page_datal1", base + 5, ld(2'b01, 1'b0, 8'h34));
        check_ld("page_datah1", base + 6, ld(2'b01, 1'b1, 8'h12));
        check_ld("page_addrh",  base + 7, ld(2'b00, 1'b1, 8'h00));
        check("page_wr_pulses", wr_pulses - wbase, 32'd1);
        check("page_wr_len", last_wr_len, 32'd2);

        // Read with command load.
        rd_word = 16'hBEEF;
        base = ld_q.size(); rbase = rsp_count;
        send(2'b11, 14'h3F81, 16'h0, 1'b0);
        wait_idle("rd1_idle", 100);
        check("rd1_nloads", ld_q.size() - base, 32'd3);
        check_ld("rd1_cmd",   base + 0, ld(2'b10, 1'b0, 8'h02));
        check_ld("rd1_addrh", base + 1, ld(2'b00, 1'b1, 8'h3F));
        check_ld("rd1_addrl", base + 2, ld(2'b00, 1'b0, 8'h81));
        check("rd1_rsp_pulses", rsp_count - rbase, 32'd1);
        check("rd1_rsp_data", {16'b0, rsp_seen}, 32'h0000BEEF);
        check("rd1_rdata_held", {16'b0, rsp_rdata}, 32'h0000BEEF);

        // Back-to-back read: command load skipped.
        rd_word = 16'h1357;
        base = ld_q.size(); rbase = rsp_count;
        send(2'b11, 14'h0123, 16'h0, 1'b0);
        wait_idle("rd2_idle", 100);
        check("rd2_nloads", ld_q.size() - base, 32'd2);
        check_ld("rd2_addrh", base + 0, ld(2'b00, 1'b1, 8'h01));
        check_ld("rd2_addrl", base + 1, ld(2'b00, 1'b0, 8'h23));
        check("rd2_rsp_pulses", rsp_count - rbase, 32'd1);
        check("rd2_rsp_data", {16'b0, rsp_seen}, 32'h00001357);

        // NOP clears last_cmd, so the next read reloads its command.
        base = ld_q.size();
        send(2'b00, 14'h0, 16'h0, 1'b0);
        wait_idle("nop_idle", 100);
        check("nop_nloads", ld_q.size() - base, 32'd1);
        check_ld("nop_cmd", base, ld(2'b10, 1'b0, 8'h00));
        rd_word = 16'h0F0F;
        base = ld_q.size();
        send(2'b11, 14'h0002, 16'h0, 1'b0);
        wait_idle("rd3_idle", 100);
        check_ld("rd3_cmd", base, ld(2'b10, 1'b0, 8'h02));
        check("rd3_rsp_data", {16'b0, rsp_seen}, 32'h00000F0F);

        // Reset during DATA_H, then the next write must reissue its command.
        send(2'b10, 14'h0010, 16'hC3C3, 1'b0);
        n = 0;
        while (!(XA == 2'b01 && BS1 == 1'b1) && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("reach_datah", {30'b0, XA, BS1} == 32'd3, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outs("midrst");
        @(negedge clk); #1;
        rst = 1'b0;
        check("midrst_ready_before_edge", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("midrst_ready_after_edge", {31'b0, req_ready}, 32'd1);
        @(negedge clk); #1;
        base = ld_q.size();
        send(2'b10, 14'h0007, 16'h00FF, 1'b0);
        wait_idle("wr3_idle", 100);
        check("wr3_nloads", ld_q.size() - base, 32'd4);
        check_ld("wr3_cmd", base, ld(2'b10, 1'b0, 8'h10));

`ifdef PP_TIMEOUT_EN
        // RDY never returns after the erase pulse.
        stick = 1'b1;
        send(2'b01, 14'h0, 16'h0, 1'b0);
        n = 0;
        while (!err && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check("timeout_err", {31'b0, err}, 32'd1);
        check("timeout_ready", {31'b0, req_ready}, 32'd0);
        check("timeout_latency_min", n >= 100, 32'd1);
        repeat (5) @(negedge clk);
        #1;
        check("timeout_err_sticky", {31'b0, err}, 32'd1);
        stick = 1'b0;
        rst = 1'b1;
        #1;
        check("timeout_err_cleared", {31'b0, err}, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
`else
        check("err_tied_low", {31'b0, err}, 32'd0);
`endif

        check("xtal_high_len", xtal_bad, 32'd0);
        check("oe_doe_overlap", oe_viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_pp_host.md
FLASH_PP_HOST -- requirements
Module: flash_pp_host

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 1 bit: request present.
REQ-004 SHALL have port req_ready, output, 1 bit: request accepted when req_valid and req_ready are both high.
REQ-005 SHALL have port req_op, input, 2 bits: operation code (see REQ-018).
REQ-006 SHALL have port req_addr, input, 14 bits: flash word address.
REQ-007 SHALL have port req_wdata, input, 16 bits: write word.
REQ-008 SHALL have port req_last, input, 1 bit: last word of the page; commit the page after this word.
REQ-009 SHALL have ports rsp_valid, output, 1 bit, and rsp_rdata, output, 16 bits: read result, presented for a one-cycle pulse.
REQ-010 SHALL have port err, output, 1 bit: RDY timeout sticky flag.
REQ-011 SHALL have ports XA, output, 2 bits; BS1, output, 1 bit; XTAL1, output, 1 bit: the flash command strobe.
REQ-012 SHALL have ports WR and OE, outputs, 1 bit each, active low.
REQ-013 SHALL have ports DATA_out, output, 8 bits; DATA_oe, output, 1 bit; DATA_in, input, 8 bits.
REQ-014 SHALL have port RDY, input, 1 bit: flash ready.
REQ-015 SHALL have parameter XTAL_HI, default 2: number of cycles XTAL1 is held high per load.
REQ-016 SHALL have parameter WR_LO, default 2: number of cycles WR is held low.
REQ-017 SHALL have parameter TIMEOUT_CYC, default 65535: number of RDY wait cycles before timeout.

Function
REQ-018 SHALL support these req_op values: 00 = NOP to flash (command 0x00); 01 = chip erase (0x80); 10 = write word; 11 = read word (0x02).
REQ-019 SHALL run each load as three phases: setup, then strobe, then hold.
- Setup: 1 cycle; XA, BS1 and DATA_out set, XTAL1=0.
- Strobe: XTAL1=1 for XTAL_HI cycles.
- Hold: 1 cycle; XTAL1=0 and values unchanged.
REQ-020 SHALL implement the load types as follows:
- CMD: XA=10, BS1=0.
- ADDR_L: XA=00, BS1=0, addr[7:0].
- ADDR_H: XA=00, BS1=1, {2'b00, addr[13:8]}.
- DATA_L: XA=01, BS1=0.
- DATA_H: XA=01, BS1=1.
REQ-021 SHALL implement the states IDLE, CMD, ADDR_H, ADDR_L, DATA_L, DATA_H, WR_PULSE, WAIT_RDY, RD_L, RD_H and RESP.
REQ-022 SHALL assert req_ready only in IDLE, with RDY=1 and err=0; the request is captured into registers on acceptance.
REQ-023 SHALL skip the CMD load when the registered last_cmd equals the required command.
- last_cmd is updated after each CMD load.
- Chip erase and NOP always issue their CMD load.
REQ-024 SHALL sequence chip erase as CMD, then WR_PULSE, then WAIT_RDY, then IDLE; last_cmd is cleared afterwards.
REQ-025 SHALL sequence write as [CMD], ADDR_L, DATA_L, DATA_H.
- If req_last=1, the sequence continues ADDR_H, WR_PULSE, WAIT_RDY, then returns to IDLE.
- Otherwise it returns to IDLE directly.
REQ-026 SHALL drive WR low for WR_LO cycles in WR_PULSE; WAIT_RDY first waits for RDY=0 (bounded to 4 cycles), then waits for RDY=1.
REQ-027 SHALL sequence read as [CMD], ADDR_H, ADDR_L, RD_L, RD_H, RESP.
REQ-028 SHALL drive DATA_oe=0 throughout RD_L and RD_H.
- RD_L: OE=0, BS1=0 for 2 cycles; DATA_in sampled on the 2nd cycle into rdata[7:0].
- RD_H: as RD_L with BS1=1, sampling into rdata[15:8].
- OE returns to 1 in RESP.
REQ-029 SHALL, in RESP, pulse rsp_valid for 1 cycle with rsp_rdata stable, then return to IDLE.
REQ-030 SHALL never have DATA_oe=1 while OE=0.
REQ-031 SHALL treat req_op=00 as a CMD load only; last_cmd is cleared.
REQ-032 SHALL ignore requests presented while req_ready=0; there is no queueing.

Reset
REQ-033 SHALL, on rst, immediately (asynchronously) drive these values:
- State = IDLE.
- XA=00, BS1=0, XTAL1=0, WR=1, OE=1.
- DATA_out=0, DATA_oe=0.
- req_ready=0 until the first clock edge after rst is released.
- rsp_valid=0, rsp_rdata=0, err=0, last_cmd=NONE.
REQ-034 SHALL, on reset in mid-operation, abandon the sequence; the flash is left in whatever state it reached, and the next request re-issues CMD.

Configuration
REQ-035 SHALL, with macro PP_TIMEOUT_EN defined, time out the wait for RDY=1 in WAIT_RDY.
- A 16-bit counter counts the wait; at TIMEOUT_CYC it sets err and returns to IDLE.
- err clears only on rst.
REQ-036 SHALL, without PP_TIMEOUT_EN, wait in WAIT_RDY indefinitely; err is tied to 0 and no counter is present.

Structure
REQ-037 SHALL place in the shared package flash_pp_pkg:
- the state enum;
- the op enum;
- the XA codes;
- the command byte constants CMD_NOP, CMD_CHIP_ERASE, CMD_WRITE_FLASH and CMD_READ_FLASH.
REQ-038 SHALL use one sub-module, flash_pp_strobe, which generates the setup/strobe/hold timing for one load and returns a done pulse.

Verification
REQ-039 SHALL cover chip erase: op=01; expect CMD 0x80, then WR low for 2 cycles; hold RDY=0 for 50 cycles; expect return to IDLE and req_ready high.
REQ-040 SHALL cover a page write: two writes, addr 0x0005 data 0xA55A (last=0) and addr 0x0006 data 0x1234 (last=1).
- Expect exactly one CMD 0x10.
- Expect data bytes 5A, A5, 34, 12.
- Expect ADDR_H byte 0x00, then a WR pulse.
REQ-041 SHALL cover a read: op=11, addr 0x3F81, flash model returns 0xBEEF.
- Expect ADDR_H byte 0x3F, then ADDR_L byte 0x81.
- Expect rsp_rdata=0xBEEF with a single rsp_valid pulse.
- Expect DATA_oe=0 while OE=0.
REQ-042 SHALL cover back-to-back reads: the second read issues no CMD load.
REQ-043 SHALL cover timeout: with PP_TIMEOUT_EN and TIMEOUT_CYC=100, RDY stuck at 0; expect err=1 after 100 cycles and req_ready=0.
REQ-044 SHALL cover reset mid-write: assert rst during DATA_H; expect all outputs at reset values on the same cycle, and the next write issues CMD 0x10.
